// File: rtl/stb_readout_sequencer.sv
// ============================================================================
// Module   : stb_readout_sequencer
// Brief    : Runs one StreamTraceBuffer capture/readout cycle. It writes the
//            control word, polls status until the trigger-event bit is set,
//            then drains DEPTH data words into a ready/valid stream with LAST.
// Options  : `define STB_TIMEOUT_EN adds a status-poll timeout of
//            TIMEOUT_CYCLES cycles with a TIMEOUT_O pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stb_readout_sequencer #(
    parameter int CTRL_W         = 32,
    parameter int STAT_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 16,
    parameter int EVENT_BIT      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              START_I,
    input  logic              ABORT_I,
    input  logic [CTRL_W-1:0] CONFIG_I,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic              ABORTED_O,
    output logic              TIMEOUT_O,
    output logic              CONTROL_VALID_O,
    input  logic              CONTROL_READY_I,
    output logic [CTRL_W-1:0] CONTROL_O,
    output logic              STATUS_READY_O,
    input  logic              STATUS_VALID_I,
    input  logic [STAT_W-1:0] STATUS_I,
    output logic              DATA_READY_O,
    input  logic              DATA_VALID_I,
    input  logic [DATA_W-1:0] DATA_I,
    output logic              OUT_VALID_O,
    input  logic              OUT_READY_I,
    output logic [DATA_W-1:0] OUT_DATA_O,
    output logic              OUT_LAST_O
);

    // Word counter saturates at DEPTH, so it needs to represent DEPTH itself.
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CONFIG  = 3'd1;
    localparam logic [2:0] ST_POLL    = 3'd2;
    localparam logic [2:0] ST_READOUT = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CTRL_W-1:0] control_q;
    logic [CNT_W-1:0]  rx_cnt_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              aborted_q;

    logic w_ctrl_hs;
    logic w_event_hs;
    logic w_data_hs;
    logic w_out_hs;
    logic w_abort;
    logic w_timeout_hit;
    logic w_unused_status;

    assign w_ctrl_hs  = CONTROL_VALID_O & CONTROL_READY_I;
    assign w_event_hs = STATUS_READY_O & STATUS_VALID_I & STATUS_I[EVENT_BIT];
    assign w_data_hs  = DATA_READY_O & DATA_VALID_I;
    assign w_out_hs   = out_valid_q & OUT_READY_I;
    // Abort only acts on a running sequence; in IDLE it is ignored.
    assign w_abort    = ABORT_I & (state_q != ST_IDLE);

    // Only the event bit of the status word carries meaning here.
    assign w_unused_status = ^STATUS_I;

`ifdef STB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] poll_cnt_q;
    logic            timeout_q;

    // Terminal poll cycle; a qualifying status in the same cycle wins.
    assign w_timeout_hit = (state_q == ST_POLL) && (poll_cnt_q == TO_LAST) && !w_event_hs;

    // Poll cycle counter: held at zero outside POLL, so it restarts on entry.
    always_ff @(posedge CLK_I) begin
        if (RST_I || (state_q != ST_POLL)) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + TO_W'(1);
        end
    end

    // One-cycle timeout pulse; an abort in the same cycle reports as abort.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= w_timeout_hit & ~w_abort;
        end
    end

    assign TIMEOUT_O = timeout_q;
`else
    assign w_timeout_hit = 1'b0;
    assign TIMEOUT_O     = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START_I) state_d = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (w_abort)        state_d = ST_IDLE;
                else if (w_ctrl_hs) state_d = ST_POLL;
            end
            ST_POLL: begin
                if (w_abort)            state_d = ST_IDLE;
                else if (w_event_hs)    state_d = ST_READOUT;
                else if (w_timeout_hit) state_d = ST_IDLE;
            end
            ST_READOUT: begin
                if (w_abort)                     state_d = ST_IDLE;
                else if (w_out_hs && out_last_q) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state channel strobes; data ready lets a new word in as the old one leaves.
    always_comb begin
        BUSY_O          = (state_q != ST_IDLE);
        DONE_O          = (state_q == ST_FINISH);
        CONTROL_VALID_O = (state_q == ST_CONFIG);
        STATUS_READY_O  = (state_q == ST_POLL);
        DATA_READY_O    = (state_q == ST_READOUT) && (rx_cnt_q < DEPTH_C) &&
                          (!out_valid_q || OUT_READY_I);
    end

    // Control word latch, captured only when a start is accepted in IDLE.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            control_q <= '0;
        end else if ((state_q == ST_IDLE) && START_I) begin
            control_q <= CONFIG_I;
        end
    end

    // Single-entry output register and received-word counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I || w_abort || (state_q == ST_IDLE) || (state_q == ST_FINISH)) begin
            rx_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (state_q == ST_READOUT) begin
            if (w_data_hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= DATA_I;
                out_last_q  <= (rx_cnt_q == LAST_C);
                rx_cnt_q    <= rx_cnt_q + CNT_W'(1);
            end else if (w_out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // One-cycle abort pulse, raised the cycle the sequence returns to IDLE.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= w_abort;
        end
    end

    assign ABORTED_O   = aborted_q;
    assign CONTROL_O   = control_q;
    assign OUT_VALID_O = out_valid_q;
    assign OUT_DATA_O  = out_data_q;
    assign OUT_LAST_O  = out_last_q;

endmodule

`default_nettype wire
